// File: rtl/next_pc_unit_if.sv
// rtl/next_pc_unit_if.sv - request/response bundle between fetch control and the next-PC unit
interface next_pc_unit_if;
    logic        iStall;
    logic        iHaltReq;
    logic        iResume;
    logic        iException;
    logic        iBranchTaken;
    logic [31:0] iBranchTarget;
    logic        iJump;
    logic [31:0] iJumpTarget;
    logic        iJumpIsCall;
    logic        iJumpIsRet;
    logic [31:0] oNextPC;
    logic [31:0] oPCPlus4;
    logic        oHalt;
    logic        oFlush;
    logic [1:0]  oState;

    // Requester side: drives the redirect/stall/halt requests, observes the PC.
    modport master (
        output iStall, iHaltReq, iResume, iException,
               iBranchTaken, iBranchTarget, iJump, iJumpTarget,
               iJumpIsCall, iJumpIsRet,
        input  oNextPC, oPCPlus4, oHalt, oFlush, oState
    );

    // Next-PC unit side.
    modport slave (
        input  iStall, iHaltReq, iResume, iException,
               iBranchTaken, iBranchTarget, iJump, iJumpTarget,
               iJumpIsCall, iJumpIsRet,
        output oNextPC, oPCPlus4, oHalt, oFlush, oState
    );
endinterface

// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - registered next-PC select with BOOT/RUN/HALT control; return stack under NPC_RAS_EN
module next_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0100,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    next_pc_unit_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        halt_q, halt_d;
    logic        flush_q, flush_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic        jump_accept;

    assign pc_plus4   = pc_q + 32'd4;
    assign branch_tgt = {bus.iBranchTarget[31:2], 2'b00};

    // A jump is taken only in RUN when no higher-priority redirect is present;
    // the return stack moves only on accepted jumps.
    assign jump_accept = (state_q == ST_RUN) && bus.iJump &&
                         !bus.iException && !bus.iBranchTaken;

`ifdef NPC_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    // ptr points at the next slot to write; the top of stack is the slot before it.
    logic [31:0]   ras_q [RAS_DEPTH];
    logic [31:0]   ras_d [RAS_DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ras_hit;
    logic [PW-1:0] ptr_prev;
    logic          unused_tgt_lsb;

    assign unused_tgt_lsb = ^{bus.iBranchTarget[1:0], bus.iJumpTarget[1:0]};
    assign ptr_prev       = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - 1'b1;

    // Return stack update: pop (if non-empty) then push, so call+ret replaces the top.
    always_comb begin
        ras_d   = ras_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ras_hit = 1'b0;
        if (jump_accept && bus.iJumpIsRet && (cnt_q != '0)) begin
            ras_hit = 1'b1;
            ptr_d   = ptr_prev;
            cnt_d   = cnt_q - 1'b1;
        end
        if (jump_accept && bus.iJumpIsCall) begin
            ras_d[ptr_d] = pc_plus4;
            ptr_d        = (int'(ptr_d) == RAS_DEPTH - 1) ? '0 : ptr_d + 1'b1;
            if (int'(cnt_d) != RAS_DEPTH) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    assign jump_tgt = ras_hit ? ras_q[ptr_prev] : {bus.iJumpTarget[31:2], 2'b00};

    // Return stack storage; reset empties it and clears entries.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ras_q <= ras_d;
        end
    end
`else
    logic unused_tgt_lsb;

    assign unused_tgt_lsb = ^{bus.iBranchTarget[1:0], bus.iJumpTarget[1:0],
                              bus.iJumpIsCall, bus.iJumpIsRet};
    assign jump_tgt       = {bus.iJumpTarget[31:2], 2'b00};
`endif

    // Run/halt control and next-PC priority select.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        halt_d  = halt_q;
        flush_d = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                pc_d    = RESET_VECTOR;
                state_d = ST_RUN;
                halt_d  = 1'b0;
            end
            ST_RUN: begin
                if (bus.iException) begin
                    pc_d    = EXC_VECTOR;
                    flush_d = 1'b1;
                end else if (bus.iBranchTaken) begin
                    pc_d    = branch_tgt;
                    flush_d = 1'b1;
                end else if (bus.iJump) begin
                    pc_d    = jump_tgt;
                    flush_d = 1'b1;
                end else if (bus.iStall || bus.iHaltReq) begin
                    pc_d    = pc_q;
                end else begin
                    pc_d    = pc_plus4;
                end
                if (bus.iHaltReq) begin
                    state_d = ST_HALT;
                    halt_d  = 1'b1;
                end
            end
            ST_HALT: begin
                if (bus.iException) begin
                    pc_d    = EXC_VECTOR;
                    flush_d = 1'b1;
                    state_d = ST_RUN;
                    halt_d  = 1'b0;
                end else if (bus.iResume) begin
                    pc_d    = pc_plus4;
                    state_d = ST_RUN;
                    halt_d  = 1'b0;
                end
            end
            default: begin
                pc_d    = RESET_VECTOR;
                state_d = ST_BOOT;
                halt_d  = 1'b0;
            end
        endcase
    end

    // State, PC and status registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            halt_q  <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            halt_q  <= halt_d;
            flush_q <= flush_d;
        end
    end

    assign bus.oNextPC  = pc_q;
    assign bus.oPCPlus4 = pc_plus4;
    assign bus.oHalt    = halt_q;
    assign bus.oFlush   = flush_q;
    assign bus.oState   = state_q;

endmodule
